// File: rtl/rop_ba_cop_mem_bridge_pkg.sv
// Shared definitions for the co-processor memory bridge: FSM encodings, timeout default,
// the registered bus request record and the address window compare.
package rop_ba_cop_mem_bridge_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int TIMEOUT_DEFAULT = 16;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  // 33-bit compare so that base + size never wraps at the top of the address space
  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] size);
    logic [32:0] lo;
    logic [32:0] hi;
    lo = {1'b0, base};
    hi = {1'b0, base} + {1'b0, size};
    return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
  endfunction

endpackage

// File: rtl/rop_ba_cop_mem_timer.sv
// Saturating phase timer: cleared on request, counts while enabled, flags the last allowed cycle.
module rop_ba_cop_mem_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int          W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  localparam logic [W-1:0] MAX  = {W{1'b1}};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/rop_ba_cop_mem_bridge.sv
// Co-processor memory port to req/gnt/rvalid bus bridge with window check and per-phase timeout.
//  state | meaning
//  IDLE  | waiting for cen (and for any orphaned response to drain)
//  REQ   | mem_req held until gnt or timeout
//  RSP   | waiting for rvalid or timeout
//  DONE  | stall released for one cycle with captured rdata/error
module rop_ba_cop_mem_bridge
  import rop_ba_cop_mem_bridge_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] ADDR_SIZE = 32'h0001_0000,
  parameter int          TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cop_mem_cen,
  input  logic        cop_mem_wen,
  input  logic [3:0]  cop_mem_ben,
  input  logic [31:0] cop_mem_addr,
  input  logic [31:0] cop_mem_wdata,
  output logic        cop_mem_stall,
  output logic        cop_mem_error,
  output logic [31:0] cop_mem_rdata,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  logic [1:0]  state_q, state_d;
  bus_req_t    req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        drain_q, drain_d;
  logic        expired;
  logic        miss;

  assign miss = !addr_in_window(cop_mem_addr, ADDR_BASE, ADDR_SIZE)
                || (cop_mem_wen && (cop_mem_ben == 4'h0));

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    drain_d = drain_q;
    // An orphaned response from a timed-out read is swallowed here
    if (drain_q && mem_rvalid) begin
      drain_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (cop_mem_cen && !drain_q) begin
          if (miss) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d     = ST_REQ;
            req_d.we    = cop_mem_wen;
            req_d.be    = cop_mem_wen ? cop_mem_ben : 4'hF;
            req_d.addr  = {cop_mem_addr[31:2], 2'b00};
            req_d.wdata = cop_mem_wdata;
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          state_d = ST_RSP;
        end else if (expired) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      ST_RSP: begin
        if (mem_rvalid) begin
          state_d = ST_DONE;
          rdata_d = mem_rdata;
          err_d   = mem_err;
        end else if (expired) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
          drain_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      drain_q <= drain_d;
    end
  end

  rop_ba_cop_mem_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_d != state_q),
    .enable  ((state_q == ST_REQ) || (state_q == ST_RSP)),
    .expired (expired)
  );

  assign cop_mem_stall = cop_mem_cen && (state_q != ST_DONE);
  assign cop_mem_error = err_q;
  assign cop_mem_rdata = rdata_q;

  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = req_q.we;
  assign mem_be    = req_q.be;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;

endmodule

// File: tb/tb_rop_ba_cop_mem_bridge.sv
// Self-checking bench for rop_ba_cop_mem_bridge: directed scenarios plus randomized accesses
// compared against a latency/result model derived from the bridge's rules.
module tb_rop_ba_cop_mem_bridge;

  localparam int          T     = 16;
  localparam logic [31:0] WBASE = 32'h0000_0000;
  localparam logic [31:0] WSIZE = 32'h0001_0000;
  localparam int          NEVER = 999;

  logic        clk = 1'b0;
  logic        reset;
  logic        cen, wen;
  logic [3:0]  ben;
  logic [31:0] addr, wdata;
  logic        stall, error;
  logic [31:0] rdata;
  logic        mem_req, gnt, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        rvalid, merr;
  logic [31:0] mrdata;

  int tests = 0;
  int fails = 0;

  int          late_cnt = -1;
  logic [31:0] late_data;

  int          r_cyc, r_reqs;
  bit          r_done;
  logic        r_err, r_we;
  logic [31:0] r_rdata, r_addr, r_wdata;
  logic [3:0]  r_be;

  always #5 clk = ~clk;

  rop_ba_cop_mem_bridge #(.ADDR_BASE(WBASE), .ADDR_SIZE(WSIZE), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .cop_mem_cen(cen), .cop_mem_wen(wen), .cop_mem_ben(ben), .cop_mem_addr(addr),
    .cop_mem_wdata(wdata), .cop_mem_stall(stall), .cop_mem_error(error), .cop_mem_rdata(rdata),
    .mem_req(mem_req), .mem_gnt(gnt), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(rvalid), .mem_rdata(mrdata), .mem_err(merr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One co-processor access; the slave grants after gd cycles of mem_req and answers rd cycles later.
  task automatic run(input logic we_i, input logic [3:0] ben_i, input logic [31:0] addr_i,
                     input logic [31:0] wdata_i, input int gd, input int rd,
                     input logic [31:0] rsp_data, input logic rsp_err, input int max_cyc);
    int req_n;
    int rsp_n;
    bit granted;
    bit answered;
    req_n = 0; rsp_n = 0; granted = 0; answered = 0;
    r_reqs = 0; r_done = 0; r_cyc = max_cyc;
    cen = 1'b1; wen = we_i; ben = ben_i; addr = addr_i; wdata = wdata_i;
    for (int c = 0; c < max_cyc; c++) begin
      gnt = 1'b0; rvalid = 1'b0; mrdata = $urandom; merr = 1'($urandom);
      if (late_cnt == 0) begin
        rvalid = 1'b1; mrdata = late_data; merr = 1'b0;
      end
      if (late_cnt >= 0) late_cnt--;
      if (granted && !answered) begin
        if (rsp_n == rd) begin
          rvalid = 1'b1; mrdata = rsp_data; merr = rsp_err; answered = 1;
        end
        rsp_n++;
      end
      if (mem_req === 1'b1) begin
        if (req_n == 0) begin
          r_addr = mem_addr; r_be = mem_be; r_we = mem_we; r_wdata = mem_wdata;
        end
        r_reqs++;
        if (req_n == gd) begin
          gnt = 1'b1; granted = 1;
        end
        req_n++;
      end
      #1;
      if (stall === 1'b0) begin
        r_cyc = c; r_done = 1; r_err = error; r_rdata = rdata;
        break;
      end
      @(negedge clk);
    end
    if (r_done) begin
      @(negedge clk);
      gnt = 1'b0; rvalid = 1'b0;
      #1;
      check("stall_back_after_done", 32'(stall), 32'd1);
      cen = 1'b0;
      @(negedge clk);
    end
  endtask

  // Reference model: outcome and timing from the bridge rules, not from its state machine.
  task automatic access(input string tag, input logic we_i, input logic [3:0] ben_i,
                        input logic [31:0] addr_i, input logic [31:0] wdata_i,
                        input int gd, input int rd, input logic [31:0] rsp_data,
                        input logic rsp_err);
    bit   miss;
    int   exp_cyc;
    int   exp_reqs;
    logic exp_err;
    longint a;
    a = longint'(addr_i);
    miss = (a < longint'(WBASE)) || (a >= longint'(WBASE) + longint'(WSIZE))
           || (we_i && ben_i == 4'h0);
    if (miss) begin
      exp_cyc = 1; exp_reqs = 0; exp_err = 1'b1;
    end else if (gd >= T) begin
      exp_cyc = 1 + T; exp_reqs = T; exp_err = 1'b1;
    end else if (rd >= T) begin
      exp_cyc = 2 + gd + T; exp_reqs = gd + 1; exp_err = 1'b1;
    end else begin
      exp_cyc = 3 + gd + rd; exp_reqs = gd + 1; exp_err = rsp_err;
    end
    run(we_i, ben_i, addr_i, wdata_i, gd, rd, rsp_data, rsp_err, 200);
    check({tag, "_done"}, 32'(r_done), 32'd1);
    check({tag, "_latency"}, 32'(r_cyc), 32'(exp_cyc));
    check({tag, "_error"}, 32'(r_err), 32'(exp_err));
    check({tag, "_req_cycles"}, 32'(r_reqs), 32'(exp_reqs));
    if (!exp_err && !we_i) check({tag, "_rdata"}, r_rdata, rsp_data);
    if (exp_reqs > 0) begin
      check({tag, "_mem_addr"}, r_addr, addr_i & 32'hFFFF_FFFC);
      check({tag, "_mem_be"}, 32'(r_be), 32'(we_i ? ben_i : 4'hF));
      check({tag, "_mem_we"}, 32'(r_we), 32'(we_i));
      check({tag, "_mem_wdata"}, r_wdata, wdata_i);
    end
  endtask

  initial begin
    reset = 1'b1; cen = 1'b0; wen = 1'b0; ben = 4'h0; addr = '0; wdata = '0;
    gnt = 1'b0; rvalid = 1'b0; mrdata = '0; merr = 1'b0; late_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    cen = 1'b1;
    #1;
    check("reset_stall_follows_cen", 32'(stall), 32'd1);
    cen = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    access("t1_load", 1'b0, 4'h0, 32'h0000_0010, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0);
    access("t2_store", 1'b1, 4'b1000, 32'h0000_0103, 32'h1122_3344, 5, 0, 32'h0, 1'b0);
    access("t3_miss", 1'b0, 4'hF, 32'h0001_0000, 32'h0, 0, 0, 32'h0, 1'b0);
    access("t4_gnt_timeout", 1'b0, 4'hF, 32'h0000_0200, 32'h0, NEVER, 0, 32'h0, 1'b0);
    repeat (3) begin
      #1;
      check("t4_no_bus_after", 32'(mem_req), 32'd0);
      @(negedge clk);
    end
    access("top_of_window", 1'b0, 4'h0, 32'h0000_FFFF, 32'h0, 1, 2, 32'h0BAD_F00D, 1'b0);
    access("bus_err", 1'b1, 4'h3, 32'h0000_0040, 32'hCAFE_0001, 0, 1, 32'h0, 1'b1);
    access("store_ben0", 1'b1, 4'h0, 32'h0000_0040, 32'h1, 0, 0, 32'h0, 1'b0);
    access("wrap_addr", 1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0, 0, 0, 32'h0, 1'b0);

    access("t5_rsp_timeout", 1'b0, 4'hF, 32'h0000_0080, 32'h0, 0, NEVER, 32'h0, 1'b0);
    late_cnt = 4; late_data = 32'hAAAA_5555;
    run(1'b0, 4'hF, 32'h0000_0084, 32'h0, 0, 0, 32'h1234_5678, 1'b0, 200);
    check("t5_second_done", 32'(r_done), 32'd1);
    check("t5_second_latency", 32'(r_cyc), 32'd8);
    check("t5_second_error", 32'(r_err), 32'd0);
    check("t5_second_rdata", r_rdata, 32'h1234_5678);

    run(1'b0, 4'hF, 32'h0000_0020, 32'h0, 0, NEVER, 32'h0, 1'b0, 4);
    check("t6_in_rsp_not_done", 32'(r_done), 32'd0);
    reset = 1'b1; cen = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    @(negedge clk);
    #1;
    check("t6_reset_mem_req", 32'(mem_req), 32'd0);
    check("t6_reset_stall", 32'(stall), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    access("t6_after_reset", 1'b0, 4'hF, 32'h0000_0024, 32'h0, 0, 0, 32'h5A5A_A5A5, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic        we_r;
      logic [3:0]  ben_r;
      logic [31:0] addr_r;
      int          gd_r;
      int          rd_r;
      we_r  = 1'($urandom);
      ben_r = 4'($urandom);
      case ($urandom_range(0, 4))
        0:       addr_r = 32'h0001_0000 + $urandom_range(0, 32'h00FF_FFFF);
        1:       addr_r = 32'h0000_FFFC + $urandom_range(0, 7);
        default: addr_r = $urandom_range(0, 32'h0000_FFFF);
      endcase
      gd_r = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 4);
      rd_r = $urandom_range(0, 4);
      access("rand", we_r, ben_r, addr_r, $urandom, gd_r, rd_r, $urandom,
             1'($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
